// File: rtl/conv_relu_pool_mc.sv
// Multi-channel 3x3 convolution with shift/ReLU clamp and optional 2x2 max-pool.
// Coefficients are loaded once after reset; pixels then stream frame after frame.
module conv_relu_pool_mc #(
   parameter int PIXEL_DATAW = 8,
   parameter int COEFF_DATAW = 8,
   parameter int IMG_W_MAX   = 64,
   parameter int NUM_CH      = 2,
   parameter int SHIFT       = 0
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [$clog2(IMG_W_MAX+1)-1:0]    cfg_img_w,
   input  logic [15:0]                       cfg_img_h,
   input  logic                              cfg_pool_en,
   input  logic                              i_coeff_valid,
   input  logic [COEFF_DATAW-1:0]            i_coeff,
   output logic                              o_coeff_ready,
   input  logic                              i_valid,
   input  logic [PIXEL_DATAW-1:0]            i_x,
   output logic                              o_ready,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [NUM_CH*PIXEL_DATAW-1:0]     o_y,
   output logic                              o_last
);
   localparam int WW = $clog2(IMG_W_MAX + 1);
   localparam int LW = $clog2(IMG_W_MAX);
   localparam int PW = $clog2(IMG_W_MAX / 2);
   localparam int SW = COEFF_DATAW + PIXEL_DATAW + 5;
   localparam int NK = NUM_CH * 9;
   localparam int KW = $clog2(NK);
   localparam logic signed [SW-1:0] PIX_MAX = {{(SW-PIXEL_DATAW){1'b0}}, {PIXEL_DATAW{1'b1}}};

   typedef enum logic [0:0] {LOAD = 1'b0, RUN = 1'b1} state_t;

   function automatic logic signed [SW-1:0] sext_coeff(input logic [COEFF_DATAW-1:0] c);
      return {{(SW-COEFF_DATAW){c[COEFF_DATAW-1]}}, c};
   endfunction

   function automatic logic signed [SW-1:0] zext_pix(input logic [PIXEL_DATAW-1:0] p);
      return {{(SW-PIXEL_DATAW){1'b0}}, p};
   endfunction

   state_t                                state_r;
   logic [KW-1:0]                         kidx_r;
   logic                                  coeff_ready_r;
   logic [COEFF_DATAW-1:0]                coeff_r [NK];
   logic [WW-1:0]                         col_r, img_w_r, w_s;
   logic [15:0]                           row_r, img_h_r, h_s;
   logic                                  pool_en_r, pool_s;
   logic [PIXEL_DATAW-1:0]                lb0_r [IMG_W_MAX];
   logic [PIXEL_DATAW-1:0]                lb1_r [IMG_W_MAX];
   logic [PIXEL_DATAW-1:0]                win_r [3][2];
   logic [PIXEL_DATAW-1:0]                nw_s  [3][3];
   logic signed [SW-1:0]                  mac_s [NUM_CH];
   logic signed [SW-1:0]                  sh_s  [NUM_CH];
   logic                                  s1_valid_r, s1_last_r, s1_pool_r, s1_rodd_r, s1_codd_r;
   logic [PW-1:0]                         s1_pidx_r, s2_pidx_r;
   logic signed [SW-1:0]                  s1_sum_r [NUM_CH];
   logic                                  s2_valid_r, s2_last_r, s2_pool_r, s2_rodd_r, s2_codd_r;
   logic [NUM_CH-1:0][PIXEL_DATAW-1:0]    s2_y_r, relu_s, hmax_s, y_next_s, y_r;
   logic [PIXEL_DATAW-1:0]                hold_r [NUM_CH];
   logic [PIXEL_DATAW-1:0]                pbuf_r [NUM_CH][IMG_W_MAX/2];
   logic                                  o_valid_r, o_last_r;
   logic                                  first_s, last_col_s, last_row_s, conv_s, last_s;
   logic                                  adv_s, px_fire_s, emit_s;

   // A frame's geometry is taken from cfg_* on its first pixel and held for the rest.
   assign first_s    = (col_r == {WW{1'b0}}) && (row_r == 16'd0);
   assign w_s        = first_s ? cfg_img_w : img_w_r;
   assign h_s        = first_s ? cfg_img_h : img_h_r;
   assign pool_s     = first_s ? cfg_pool_en : pool_en_r;
   assign last_col_s = (col_r == w_s - WW'(1));
   assign last_row_s = (row_r == h_s - 16'd1);
   assign conv_s     = (row_r >= 16'd2) && (col_r >= WW'(2));
   assign last_s     = pool_s ? (row_r[0] && col_r[0] && (row_r >= h_s - 16'd2) && (col_r >= w_s - WW'(2)))
                              : (last_row_s && last_col_s);

   assign adv_s         = !(o_valid_r && !i_ready);
   assign o_ready       = (state_r == RUN) && adv_s;
   assign px_fire_s     = i_valid && o_ready;
   assign emit_s        = s2_valid_r && (!s2_pool_r || (s2_rodd_r && s2_codd_r));
   assign o_coeff_ready = coeff_ready_r;
   assign o_valid       = o_valid_r;
   assign o_last        = o_last_r;
   assign o_y           = y_r;

   // Window including the incoming pixel, then the per-channel MAC over it.
   always_comb begin
      for (int kr = 0; kr < 2; kr++) begin
         nw_s[kr][0] = win_r[kr][0];
         nw_s[kr][1] = win_r[kr][1];
      end
      nw_s[2][0] = win_r[2][0];
      nw_s[2][1] = win_r[2][1];
      nw_s[0][2] = lb1_r[col_r[LW-1:0]];
      nw_s[1][2] = lb0_r[col_r[LW-1:0]];
      nw_s[2][2] = i_x;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         mac_s[ch] = {SW{1'b0}};
         for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
               mac_s[ch] = mac_s[ch] + sext_coeff(coeff_r[ch*9 + kr*3 + kc]) * zext_pix(nw_s[kr][kc]);
            end
         end
      end
   end

   // Arithmetic shift then clamp into the unsigned pixel range.
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         sh_s[ch] = s1_sum_r[ch] >>> SHIFT;
         if (sh_s[ch][SW-1]) begin
            relu_s[ch] = {PIXEL_DATAW{1'b0}};
         end else if (sh_s[ch] > PIX_MAX) begin
            relu_s[ch] = {PIXEL_DATAW{1'b1}};
         end else begin
            relu_s[ch] = sh_s[ch][PIXEL_DATAW-1:0];
         end
      end
   end

   // Horizontal pair max, then against the stored pair max of the row above.
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         hmax_s[ch]   = (hold_r[ch] > s2_y_r[ch]) ? hold_r[ch] : s2_y_r[ch];
         y_next_s[ch] = s2_y_r[ch];
         if (s2_pool_r) begin
            y_next_s[ch] = (pbuf_r[ch][s2_pidx_r] > hmax_s[ch]) ? pbuf_r[ch][s2_pidx_r] : hmax_s[ch];
         end else begin
            y_next_s[ch] = s2_y_r[ch];
         end
      end
   end

   // Storage arrays; stale contents are never consumed because the counters gate every use.
   always_ff @(posedge clk) begin
      if (state_r == LOAD && i_coeff_valid) begin
         coeff_r[kidx_r] <= i_coeff;
      end
      if (px_fire_s) begin
         lb1_r[col_r[LW-1:0]] <= lb0_r[col_r[LW-1:0]];
         lb0_r[col_r[LW-1:0]] <= i_x;
         for (int kr = 0; kr < 3; kr++) begin
            win_r[kr][0] <= win_r[kr][1];
            win_r[kr][1] <= nw_s[kr][2];
         end
      end
      if (adv_s && s2_valid_r && s2_pool_r) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!s2_codd_r) begin
               hold_r[ch] <= s2_y_r[ch];
            end else if (!s2_rodd_r) begin
               pbuf_r[ch][s2_pidx_r] <= hmax_s[ch];
            end
         end
      end
   end

   // Load/run FSM, raster counters and the three pipeline registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r       <= LOAD;
         kidx_r        <= {KW{1'b0}};
         coeff_ready_r <= 1'b1;
         col_r         <= {WW{1'b0}};
         row_r         <= 16'd0;
         img_w_r       <= {WW{1'b0}};
         img_h_r       <= 16'd0;
         pool_en_r     <= 1'b0;
         s1_valid_r    <= 1'b0;
         s1_last_r     <= 1'b0;
         s1_pool_r     <= 1'b0;
         s1_rodd_r     <= 1'b0;
         s1_codd_r     <= 1'b0;
         s1_pidx_r     <= {PW{1'b0}};
         for (int ch = 0; ch < NUM_CH; ch++) s1_sum_r[ch] <= {SW{1'b0}};
         s2_valid_r    <= 1'b0;
         s2_last_r     <= 1'b0;
         s2_pool_r     <= 1'b0;
         s2_rodd_r     <= 1'b0;
         s2_codd_r     <= 1'b0;
         s2_pidx_r     <= {PW{1'b0}};
         s2_y_r        <= {(NUM_CH*PIXEL_DATAW){1'b0}};
         o_valid_r     <= 1'b0;
         o_last_r      <= 1'b0;
         y_r           <= {(NUM_CH*PIXEL_DATAW){1'b0}};
      end else begin
         case (state_r)
            LOAD: begin
               if (i_coeff_valid) begin
                  kidx_r <= kidx_r + KW'(1);
                  if (kidx_r == KW'(NK - 1)) begin
                     state_r       <= RUN;
                     coeff_ready_r <= 1'b0;
                  end
               end
            end
            RUN: state_r <= RUN;
            default: begin
               state_r       <= LOAD;
               kidx_r        <= {KW{1'b0}};
               coeff_ready_r <= 1'b1;
            end
         endcase
         if (px_fire_s) begin
            if (first_s) begin
               img_w_r   <= cfg_img_w;
               img_h_r   <= cfg_img_h;
               pool_en_r <= cfg_pool_en;
            end
            if (last_col_s) begin
               col_r <= {WW{1'b0}};
               row_r <= last_row_s ? 16'd0 : row_r + 16'd1;
            end else begin
               col_r <= col_r + WW'(1);
            end
         end
         if (adv_s) begin
            s1_valid_r <= px_fire_s && conv_s;
            s1_last_r  <= last_s;
            s1_pool_r  <= pool_s;
            s1_rodd_r  <= row_r[0];
            s1_codd_r  <= col_r[0];
            s1_pidx_r  <= col_r[PW:1];
            s1_sum_r   <= mac_s;
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            s2_pool_r  <= s1_pool_r;
            s2_rodd_r  <= s1_rodd_r;
            s2_codd_r  <= s1_codd_r;
            s2_pidx_r  <= s1_pidx_r;
            s2_y_r     <= relu_s;
            o_valid_r  <= emit_s;
            o_last_r   <= emit_s && s2_last_r;
            if (emit_s) begin
               y_r <= y_next_s;
            end
         end
      end
   end
endmodule

// File: tb/tb_conv_relu_pool_mc.sv
// Directed bench for conv_relu_pool_mc: two instances (SHIFT=0 and SHIFT=4) share stimulus.
module tb_conv_relu_pool_mc;
   localparam int PIXEL_DATAW = 8;
   localparam int COEFF_DATAW = 8;
   localparam int IMG_W_MAX   = 64;
   localparam int NUM_CH      = 2;
   localparam int WW          = $clog2(IMG_W_MAX + 1);
   localparam int YW          = NUM_CH * PIXEL_DATAW;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic [WW-1:0]          cfg_img_w;
   logic [15:0]            cfg_img_h;
   logic                   cfg_pool_en;
   logic                   i_coeff_valid;
   logic [COEFF_DATAW-1:0] i_coeff;
   logic                   i_valid;
   logic [PIXEL_DATAW-1:0] i_x;
   logic                   i_ready;
   logic                   o_coeff_ready, o_ready, o_valid, o_last;
   logic [YW-1:0]          o_y;
   logic                   o_coeff_ready1, o_ready1, o_valid1, o_last1;
   logic [YW-1:0]          o_y1;

   int checks = 0;
   int errors = 0;
   int acc22_cyc, firstv_cyc;
   logic [YW-1:0] yq[$];
   logic [YW-1:0] y1q[$];
   logic          lq[$];
   int exp4 [4] = '{16, 18, 30, 32};

   always #5 clk = ~clk;

   conv_relu_pool_mc #(.PIXEL_DATAW(PIXEL_DATAW), .COEFF_DATAW(COEFF_DATAW), .IMG_W_MAX(IMG_W_MAX),
                       .NUM_CH(NUM_CH), .SHIFT(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
      .cfg_pool_en(cfg_pool_en), .i_coeff_valid(i_coeff_valid), .i_coeff(i_coeff),
      .o_coeff_ready(o_coeff_ready), .i_valid(i_valid), .i_x(i_x), .o_ready(o_ready),
      .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y), .o_last(o_last));

   conv_relu_pool_mc #(.PIXEL_DATAW(PIXEL_DATAW), .COEFF_DATAW(COEFF_DATAW), .IMG_W_MAX(IMG_W_MAX),
                       .NUM_CH(NUM_CH), .SHIFT(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
      .cfg_pool_en(cfg_pool_en), .i_coeff_valid(i_coeff_valid), .i_coeff(i_coeff),
      .o_coeff_ready(o_coeff_ready1), .i_valid(i_valid), .i_x(i_x), .o_ready(o_ready1),
      .o_valid(o_valid1), .i_ready(i_ready), .o_y(o_y1), .o_last(o_last1));

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int coeff_val(input int kind, input int k);
      case (kind)
         0:       return (k % 9 == 4) ? 1 : 0;
         1:       return (k / 9 == 0) ? 1 : -1;
         2:       return 127;
         default: return 1;
      endcase
   endfunction

   function automatic int pix_val(input int mode, input int f, input int r, input int c, input int w);
      case (mode)
         0:       return (f * 64 + r * w + c) % 256;
         1:       return 10;
         default: return 255;
      endcase
   endfunction

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      i_valid = 1'b0;
      i_coeff_valid = 1'b0;
      i_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_eq({tag, "_valid"}, int'(o_valid), 0);
      check_eq({tag, "_y"}, int'(o_y), 0);
      check_eq({tag, "_last"}, int'(o_last), 0);
      check_eq({tag, "_ready"}, int'(o_ready), 0);
      check_eq({tag, "_cready"}, int'(o_coeff_ready), 1);
      reset_n = 1'b1;
   endtask

   task automatic load_coeffs(input int kind);
      for (int k = 0; k < NUM_CH * 9; k++) begin
         @(negedge clk);
         i_coeff_valid = 1'b1;
         i_coeff = 8'(coeff_val(kind, k));
      end
      @(negedge clk);
      i_coeff = 8'h5A;
      #1;
      check_eq("cready_run", int'(o_coeff_ready), 0);
   endtask

   task automatic run_frames(input int h, input int w, input int pool, input int pmode,
                             input int nframes, input int stall, input int nexp);
      int pi, total, cyc, f, rem;
      logic          prev_stall;
      logic [YW-1:0] prev_y;
      logic          prev_last;
      pi = 0; cyc = 0; total = nframes * h * w;
      prev_stall = 1'b0; prev_y = '0; prev_last = 1'b0;
      acc22_cyc = -1; firstv_cyc = -1;
      yq.delete(); y1q.delete(); lq.delete();
      cfg_img_w = WW'(w); cfg_img_h = 16'(h); cfg_pool_en = (pool != 0);
      while ((pi < total || yq.size() < nexp) && cyc < 5000) begin
         @(negedge clk);
         i_ready = (stall != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (pi < total) begin
            f = pi / (h * w);
            rem = pi % (h * w);
            i_valid = (stall != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_x = 8'(pix_val(pmode, f, rem / w, rem % w, w));
         end else begin
            i_valid = 1'b0;
         end
         #1;
         if (prev_stall) begin
            check_eq("hold_valid", int'(o_valid), 1);
            check_eq("hold_y", int'(o_y), int'(prev_y));
            check_eq("hold_last", int'(o_last), int'(prev_last));
         end
         prev_stall = o_valid && !i_ready;
         prev_y = o_y;
         prev_last = o_last;
         if (o_valid && firstv_cyc < 0) firstv_cyc = cyc;
         if (o_valid && i_ready) begin
            yq.push_back(o_y); y1q.push_back(o_y1); lq.push_back(o_last);
         end
         if (i_valid && o_ready) begin
            if (pi == 2 * w + 2) acc22_cyc = cyc;
            pi++;
         end
         cyc++;
      end
      repeat (6) begin
         @(negedge clk);
         i_valid = 1'b0;
         i_ready = 1'b1;
         #1;
         if (o_valid) begin
            yq.push_back(o_y); y1q.push_back(o_y1); lq.push_back(o_last);
         end
      end
      check_eq("pixels_sent", pi, total);
      check_eq("beat_count", yq.size(), nexp);
   endtask

   task automatic check_identity6(input string tag);
      for (int i = 0; i < 16; i++) begin
         if (i < yq.size()) begin
            check_eq({tag, "_ch0"}, int'(yq[i][7:0]), (1 + i / 4) * 6 + (1 + i % 4));
            check_eq({tag, "_ch1"}, int'(yq[i][15:8]), (1 + i / 4) * 6 + (1 + i % 4));
            check_eq({tag, "_last"}, int'(lq[i]), (i == 15) ? 1 : 0);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; i_valid = 1'b0; i_coeff_valid = 1'b0; i_coeff = 8'd0; i_x = 8'd0;
      i_ready = 1'b1; cfg_img_w = WW'(6); cfg_img_h = 16'd6; cfg_pool_en = 1'b0;

      // identity kernels, 6x6 ramp, bypass
      do_reset("rst0");
      load_coeffs(0);
      run_frames(6, 6, 0, 0, 1, 0, 16);
      check_identity6("t1");
      check_eq("t1_latency", firstv_cyc - acc22_cyc, 3);

      // +1 / -1 kernels over a flat 10 frame with pooling
      do_reset("rst1");
      load_coeffs(1);
      run_frames(6, 6, 1, 1, 1, 0, 4);
      for (int i = 0; i < 4; i++) begin
         if (i < yq.size()) begin
            check_eq("t2_ch0", int'(yq[i][7:0]), 90);
            check_eq("t2_ch1", int'(yq[i][15:8]), 0);
            check_eq("t2_last", int'(lq[i]), (i == 3) ? 1 : 0);
         end
      end

      // saturation at both shifts, then 2295 >> 4
      do_reset("rst2");
      load_coeffs(2);
      run_frames(3, 3, 0, 2, 1, 0, 1);
      if (yq.size() > 0) begin
         check_eq("t3_sat_s0", int'(yq[0][7:0]), 255);
         check_eq("t3_sat_s4", int'(y1q[0][7:0]), 255);
         check_eq("t3_sat_last", int'(lq[0]), 1);
      end
      do_reset("rst3");
      load_coeffs(3);
      run_frames(3, 3, 0, 2, 1, 0, 1);
      if (yq.size() > 0) begin
         check_eq("t3_ones_s0", int'(yq[0][7:0]), 255);
         check_eq("t3_ones_s4", int'(y1q[0][7:0]), 143);
      end

      // odd 7x7 frame with pooling: trailing conv row/column dropped
      do_reset("rst4");
      load_coeffs(0);
      run_frames(7, 7, 1, 0, 1, 0, 4);
      for (int i = 0; i < 4; i++) begin
         if (i < yq.size()) begin
            check_eq("t4_ch0", int'(yq[i][7:0]), exp4[i]);
            check_eq("t4_ch1", int'(yq[i][15:8]), exp4[i]);
            check_eq("t4_last", int'(lq[i]), (i == 3) ? 1 : 0);
         end
      end

      // two back-to-back 8x8 frames under random valid/ready
      do_reset("rst5");
      load_coeffs(0);
      run_frames(8, 8, 0, 0, 2, 1, 72);
      for (int i = 0; i < 72; i++) begin
         if (i < yq.size()) begin
            check_eq("t5_ch0", int'(yq[i][7:0]), ((i / 36) * 64 + (1 + (i % 36) / 6) * 8 + (1 + (i % 36) % 6)) % 256);
            check_eq("t5_last", int'(lq[i]), ((i % 36) == 35) ? 1 : 0);
         end
      end

      // reset in the middle of a frame, reload, replay
      do_reset("rst6");
      load_coeffs(0);
      cfg_img_w = WW'(6); cfg_img_h = 16'd6; cfg_pool_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         i_ready = 1'b1;
         i_valid = 1'b1;
         i_x = 8'd99;
      end
      do_reset("rst7");
      load_coeffs(0);
      run_frames(6, 6, 0, 0, 1, 0, 16);
      check_identity6("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
